// File: rtl/hough_pkg.sv
// hough_pkg: shared types for the hysteresis BRAM arbiter
package hough_pkg;
  typedef enum logic [1:0] {FILL, READ, DRAIN} arb_state_t;
  typedef enum logic {REQ_HOUGH, REQ_HL} req_id_t;
  localparam int RD_LATENCY_MAX = 4;
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favours the requester not granted last
module rr_arb2
  import hough_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  req_id_t prio;
  always_comb gnt = !enable ? 2'b00 : (req == 2'b11) ? (prio == REQ_HL ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clock)
    if (reset) prio <= REQ_HOUGH;
    else if (|gnt) prio <= gnt[0] ? REQ_HL : REQ_HOUGH;
endmodule

// File: rtl/hysteresis_bram_arbiter.sv
// hysteresis_bram_arbiter: frame handoff of the hysteresis BRAM between writer and two readers
module hysteresis_bram_arbiter
  import hough_pkg::*;
#(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int ADDR_W     = $clog2(WIDTH * HEIGHT),
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hys_wr_en,
  input  logic [ADDR_W-1:0] hys_wr_addr,
  input  logic [7:0]        hys_wr_data,
  input  logic              hys_frame_done,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [7:0]        bram_wr_data,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [7:0]        bram_rd_data,
  input  logic              hough_req,
  input  logic [ADDR_W-1:0] hough_addr,
  output logic              hough_gnt,
  output logic              hough_rvalid,
  output logic [7:0]        hough_rdata,
  input  logic              hough_done,
  input  logic              hl_req,
  input  logic [ADDR_W-1:0] hl_addr,
  output logic              hl_gnt,
  output logic              hl_rvalid,
  output logic [7:0]        hl_rdata,
  input  logic              hl_done,
  output logic              hough_start,
  output logic              read_done,
  output logic              wr_overrun
);
  localparam int CW = $clog2(RD_LATENCY_MAX);
  arb_state_t     state;
  logic           hough_flag, hl_flag;
  logic [CW-1:0]  drain_cnt;
  rd_tag_t        tag_pipe [RD_LATENCY];
  rd_tag_t        tag_out;
  logic [1:0]     gnt;
  logic           in_fill, in_read, in_drain, drain_last, both_done;
  assign in_fill    = state == FILL;
  assign in_read    = state == READ;
  assign in_drain   = state == DRAIN;
  assign drain_last = drain_cnt == CW'(RD_LATENCY - 1);
  assign both_done  = (hough_flag | hough_done) & (hl_flag | hl_done);
  assign tag_out    = tag_pipe[RD_LATENCY-1];
  rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({hl_req & ~hl_flag, hough_req & ~hough_flag}),
    .enable (in_read),
    .gnt    (gnt)
  );
  always_comb begin
    bram_wr_en   = in_fill & hys_wr_en;
    bram_wr_addr = in_fill ? hys_wr_addr : '0;
    bram_wr_data = in_fill ? hys_wr_data : '0;
    hough_gnt    = gnt[0];
    hl_gnt       = gnt[1];
    bram_rd_addr = gnt[0] ? hough_addr : gnt[1] ? hl_addr : '0;
    hough_rvalid = tag_out.valid && tag_out.id == REQ_HOUGH;
    hl_rvalid    = tag_out.valid && tag_out.id == REQ_HL;
    hough_rdata  = hough_rvalid ? bram_rd_data : '0;
    hl_rdata     = hl_rvalid ? bram_rd_data : '0;
  end
  // Tags travel alongside the BRAM read so returning data can be routed to its requester
  always_ff @(posedge clock)
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: |gnt, id: gnt[1] ? REQ_HL : REQ_HOUGH};
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  always_ff @(posedge clock)
    if (reset) begin
      state       <= FILL;
      hough_flag  <= 1'b0;
      hl_flag     <= 1'b0;
      drain_cnt   <= '0;
      hough_start <= 1'b0;
      read_done   <= 1'b0;
      wr_overrun  <= 1'b0;
    end else begin
      state       <= (in_fill && hys_frame_done) ? READ :
                     (in_read && both_done)      ? DRAIN :
                     (in_drain && drain_last)    ? FILL : state;
      hough_flag  <= (in_read & hough_done) | (hough_flag & ~(in_drain & drain_last));
      hl_flag     <= (in_read & hl_done) | (hl_flag & ~(in_drain & drain_last));
      drain_cnt   <= in_drain ? drain_cnt + 1'b1 : '0;
      hough_start <= in_fill & hys_frame_done;
      read_done   <= in_drain & drain_last;
      wr_overrun  <= wr_overrun | (hys_wr_en & ~in_fill);
    end
endmodule

// File: tb/tb_hysteresis_bram_arbiter.sv
// tb_hysteresis_bram_arbiter: table-driven check of two arbiter instances (read latency 1 and 3)
module tb_hysteresis_bram_arbiter;
  localparam int AW = 20;
  typedef struct packed {
    logic we; logic [AW-1:0] wa; logic [7:0] wd; logic fd;
    logic hr; logic [AW-1:0] ha; logic lr; logic [AW-1:0] la; logic hdn, ldn;
  } in_t;
  typedef struct packed {
    logic we; logic [AW-1:0] wa; logic [7:0] wd; logic [AW-1:0] ra;
    logic hg, lg, hv; logic [7:0] hd; logic lv; logic [7:0] ld; logic hs, rdn, ov;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, hys_wr_en, hys_frame_done, hough_req, hl_req, hough_done, hl_done;
  logic [AW-1:0] hys_wr_addr, hough_addr, hl_addr;
  logic [7:0] hys_wr_data;
  logic bram_wr_en [2], hough_gnt [2], hough_rvalid [2], hl_gnt [2], hl_rvalid [2];
  logic hough_start [2], read_done [2], wr_overrun [2];
  logic [AW-1:0] bram_wr_addr [2], bram_rd_addr [2];
  logic [7:0] bram_wr_data [2], bram_rd_data [2], hough_rdata [2], hl_rdata [2];
  int n_tests = 0, n_fail = 0;
  vec_t t1 [23];
  vec_t t2 [16];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mem [16];
    logic [7:0] pipe [LAT];
    always_ff @(posedge clock) begin
      if (bram_wr_en[g]) mem[bram_wr_addr[g][3:0]] <= bram_wr_data[g];
      pipe[0] <= mem[bram_rd_addr[g][3:0]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_rd_data[g] = pipe[LAT-1];
    hysteresis_bram_arbiter #(.RD_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .hys_wr_en(hys_wr_en), .hys_wr_addr(hys_wr_addr), .hys_wr_data(hys_wr_data),
      .hys_frame_done(hys_frame_done),
      .bram_wr_en(bram_wr_en[g]), .bram_wr_addr(bram_wr_addr[g]), .bram_wr_data(bram_wr_data[g]),
      .bram_rd_addr(bram_rd_addr[g]), .bram_rd_data(bram_rd_data[g]),
      .hough_req(hough_req), .hough_addr(hough_addr), .hough_gnt(hough_gnt[g]),
      .hough_rvalid(hough_rvalid[g]), .hough_rdata(hough_rdata[g]), .hough_done(hough_done),
      .hl_req(hl_req), .hl_addr(hl_addr), .hl_gnt(hl_gnt[g]),
      .hl_rvalid(hl_rvalid[g]), .hl_rdata(hl_rdata[g]), .hl_done(hl_done),
      .hough_start(hough_start[g]), .read_done(read_done[g]), .wr_overrun(wr_overrun[g])
    );
  end
  function automatic in_t vi(input int we, wa, wd, fd, hr, ha, lr, la, hdn, ldn);
    return '{1'(we), AW'(wa), 8'(wd), 1'(fd), 1'(hr), AW'(ha), 1'(lr), AW'(la), 1'(hdn), 1'(ldn)};
  endfunction
  function automatic out_t vo(input int we, wa, wd, ra, hg, lg, hv, hd, lv, ld, hs, rdn, ov);
    return '{1'(we), AW'(wa), 8'(wd), AW'(ra), 1'(hg), 1'(lg), 1'(hv), 8'(hd), 1'(lv), 8'(ld),
             1'(hs), 1'(rdn), 1'(ov)};
  endfunction
  function automatic out_t act(input int k);
    return '{bram_wr_en[k], bram_wr_addr[k], bram_wr_data[k], bram_rd_addr[k], hough_gnt[k],
             hl_gnt[k], hough_rvalid[k], hough_rdata[k], hl_rvalid[k], hl_rdata[k],
             hough_start[k], read_done[k], wr_overrun[k]};
  endfunction
  task automatic apply(input in_t v);
    hys_wr_en = v.we; hys_wr_addr = v.wa; hys_wr_data = v.wd; hys_frame_done = v.fd;
    hough_req = v.hr; hough_addr = v.ha; hl_req = v.lr; hl_addr = v.la;
    hough_done = v.hdn; hl_done = v.ldn;
  endtask
  task automatic check(input int k, input out_t exp, input string nm);
    out_t got;
    got = act(k);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got=%h exp=%h", nm, k, got, exp);
    end
  endtask
  initial begin
    // frame fill, alternating reads, single read, overrun, joint done, done ignored in FILL
    t1[0]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t1[1]  = '{vi(1,0,10,0,0,0,0,0,0,0), vo(1,0,10,0,0,0,0,0,0,0,0,0,0)};
    t1[2]  = '{vi(1,1,20,0,0,0,0,0,0,0), vo(1,1,20,0,0,0,0,0,0,0,0,0,0)};
    t1[3]  = '{vi(1,2,30,0,0,0,0,0,0,0), vo(1,2,30,0,0,0,0,0,0,0,0,0,0)};
    t1[4]  = '{vi(1,3,40,0,0,0,0,0,0,0), vo(1,3,40,0,0,0,0,0,0,0,0,0,0)};
    t1[5]  = '{vi(0,0,0,1,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t1[6]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,1,0,0)};
    t1[7]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,1,1,0,0,0,0,0,0,0,0)};
    t1[8]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,3,0,1,1,20,0,0,0,0,0)};
    t1[9]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,1,1,0,0,0,1,40,0,0,0)};
    t1[10] = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,3,0,1,1,20,0,0,0,0,0)};
    t1[11] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,1,40,0,0,0)};
    t1[12] = '{vi(0,0,0,0,1,2,0,0,0,0), vo(0,0,0,2,1,0,0,0,0,0,0,0,0)};
    t1[13] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,1,30,0,0,0,0,0)};
    t1[14] = '{vi(1,5,99,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t1[15] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    t1[16] = '{vi(0,0,0,0,1,3,0,0,1,1), vo(0,0,0,3,1,0,0,0,0,0,0,0,1)};
    t1[17] = '{vi(0,0,0,0,1,3,0,0,0,0), vo(0,0,0,0,0,0,1,40,0,0,0,0,1)};
    t1[18] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,1,1)};
    t1[19] = '{vi(0,0,0,0,0,0,0,0,1,1), vo(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    t1[20] = '{vi(1,4,50,0,0,0,0,0,0,0), vo(1,4,50,0,0,0,0,0,0,0,0,0,1)};
    t1[21] = '{vi(0,0,0,1,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    t1[22] = '{vi(0,0,0,0,1,2,0,0,0,0), vo(0,0,0,2,1,0,0,0,0,0,1,0,1)};
    // same scenarios on the three-cycle read latency instance
    t2[0]  = '{vi(0,0,0,1,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t2[1]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,1,0,0)};
    t2[2]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,1,1,0,0,0,0,0,0,0,0)};
    t2[3]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,3,0,1,0,0,0,0,0,0,0)};
    t2[4]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,1,1,0,0,0,0,0,0,0,0)};
    t2[5]  = '{vi(0,0,0,0,1,1,1,3,0,0), vo(0,0,0,3,0,1,1,20,0,0,0,0,0)};
    t2[6]  = '{vi(0,0,0,0,1,2,0,0,0,0), vo(0,0,0,2,1,0,0,0,1,40,0,0,0)};
    t2[7]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,1,20,0,0,0,0,0)};
    t2[8]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,1,40,0,0,0)};
    t2[9]  = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,1,30,0,0,0,0,0)};
    t2[10] = '{vi(0,0,0,0,0,0,1,3,1,1), vo(0,0,0,3,0,1,0,0,0,0,0,0,0)};
    t2[11] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t2[12] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    t2[13] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,1,40,0,0,0)};
    t2[14] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,1,0)};
    t2[15] = '{vi(0,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    reset = 1'b1;
    apply('0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clock);
      apply(t1[i].i);
      #1;
      check(0, t1[i].o, $sformatf("t1[%0d]", i));
    end
    // reset lands while a read is in flight on both instances
    @(negedge clock);
    reset = 1'b1;
    apply('0);
    #1;
    check(0, vo(0,0,0,0,0,0,1,30,0,0,0,0,1), "rst_inflight");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 2) reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) check(k, '0, $sformatf("rst_zero[%0d]", i));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      apply(t2[i].i);
      #1;
      check(1, t2[i].o, $sformatf("t2[%0d]", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
